interrupt_controller: RTL and testbench
=======================================

INTERRUPT_CONTROLLER -- requirements
Module: interrupt_controller

Interface
REQ-001 Parameter VECTOR_BASE, default 32'd4096: handler base address; vector_pc = VECTOR_BASE + 16*irq_id.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 irq_in  input  4  level interrupt sources, asynchronous to nothing (already clk-domain), bit 0 = source 0.
REQ-005 cfg_we  input  1  write strobe for enable register.
REQ-006 cfg_wdata  input  4  new per-source enable mask.
REQ-007 interrupt_mask  input  1  global CPU mask; 1 blocks new alerts.
REQ-008 interrupt  input  1  one-cycle pulse from PC logic: vector taken (acknowledge).
REQ-009 eoi  input  1  one-cycle end-of-interrupt pulse from handler return.
REQ-010 alert  output  1  request to PC logic to enter interrupt sequence.
REQ-011 irq_id  output  2  id of source being alerted/serviced.
REQ-012 vector_pc  output  32  handler address for irq_id.
REQ-013 in_service  output  1  high while a handler runs.
REQ-014 pending  output  4  current pending register.
REQ-015 enable  output  4  current enable register.

Function
REQ-016 Rising edge of irq_in[i] (registered previous value 0, current 1) SHALL set pending[i] next cycle.
REQ-017 Eligible set = pending & enable; fixed priority, lowest index wins.
REQ-018 FSM states IDLE, ALERT, SERVICE.
REQ-019 IDLE->ALERT when eligible set nonzero and interrupt_mask==0; irq_id latched at that edge.
REQ-020 ALERT: alert=1 every cycle; irq_id, vector_pc stable; ALERT->SERVICE on interrupt==1.
REQ-021 On the ALERT->SERVICE edge pending[irq_id] SHALL clear, unless a new edge on same source occurs that cycle (set wins).
REQ-022 SERVICE: alert=0, in_service=1; SERVICE->IDLE on eoi==1; no nesting.
REQ-023 interrupt_mask rising while in ALERT SHALL NOT drop alert; mask only gates IDLE->ALERT.
REQ-024 cfg_we writes enable next cycle in any state; clearing enable of latched irq_id in ALERT SHALL NOT abort alert.
REQ-025 interrupt pulse in IDLE or SERVICE, eoi in IDLE or ALERT: ignored, no state change.
REQ-026 Latency: edge on irq_in at cycle N -> pending at N+1 -> alert at N+2 (IDLE, unmasked, enabled).
REQ-027 vector_pc combinational from registered irq_id, 32-bit, no overflow check.
REQ-028 Re-entry to ALERT from IDLE allowed the cycle after SERVICE->IDLE.

Reset
REQ-029 rst==1 at clock edge: state=IDLE, pending=0, enable=4'b1111, irq_id=0, edge-detect history=0.
REQ-030 Outputs during/after reset: alert=0, in_service=0, vector_pc=VECTOR_BASE.
REQ-031 Reset mid-ALERT or mid-SERVICE SHALL abandon the sequence; no pending retained.

Configuration
REQ-032 Macro INTC_ROUND_ROBIN_EN defined: priority rotates; search starts at (last granted id + 1) mod 4, pointer reset 3 (so source 0 first after reset), updated on ALERT->SERVICE.
REQ-033 Macro undefined: fixed priority per REQ-017; no pointer register.

Verification
REQ-034 Reset, irq_in=4'b0100 edge at cycle 5 -> alert=1 cycle 7, irq_id=2, vector_pc=4128; interrupt pulse -> in_service=1, pending=0.
REQ-035 Edges on sources 1 and 3 same cycle -> alert irq_id=1; after eoi, alert irq_id=3 next-but-one cycle (fixed priority).
REQ-036 interrupt_mask=1, edge source 0 -> pending=4'b0001, alert stays 0; mask=0 -> alert next cycle.
REQ-037 cfg_wdata=4'b1110 written, edge source 0 -> no alert; edge source 1 -> alert irq_id=1.
REQ-038 rst=1 during SERVICE -> next cycle in_service=0, pending=0, enable=4'b1111.
REQ-039 With INTC_ROUND_ROBIN_EN, sources 0 and 1 held repeatedly re-edged -> grants alternate 0,1,0,1.

Source files
------------

// File: rtl/interrupt_controller_if.sv
`default_nettype none
// ============================================================================
// Module      : interrupt_controller_if
// Description : Bundle of interrupt sources, configuration, CPU handshake and
//               status signals between the interrupt controller (slave) and
//               the PC/CPU logic driving it (master).
// Revision    : 1.0 - initial release
// ============================================================================
interface interrupt_controller_if;
    logic [3:0]  irq_in;
    logic        cfg_we;
    logic [3:0]  cfg_wdata;
    logic        interrupt_mask;
    logic        interrupt;
    logic        eoi;
    logic        alert;
    logic [1:0]  irq_id;
    logic [31:0] vector_pc;
    logic        in_service;
    logic [3:0]  pending;
    logic [3:0]  enable;

    // Controller side
    modport slave (
        input  irq_in, cfg_we, cfg_wdata, interrupt_mask, interrupt, eoi,
        output alert, irq_id, vector_pc, in_service, pending, enable
    );

    // CPU / source side
    modport master (
        output irq_in, cfg_we, cfg_wdata, interrupt_mask, interrupt, eoi,
        input  alert, irq_id, vector_pc, in_service, pending, enable
    );
endinterface
`default_nettype wire

// File: rtl/interrupt_controller.sv
`default_nettype none
// ============================================================================
// Module      : interrupt_controller
// Description : Four-source edge-triggered interrupt controller with per-source
//               enables, a global mask and an IDLE/ALERT/SERVICE handshake with
//               the PC logic. Handler address = VECTOR_BASE + 16*irq_id.
//               Optional macro INTC_ROUND_ROBIN_EN selects rotating priority
//               (search starts after the last granted id); when undefined,
//               fixed priority with the lowest index winning.
// Revision    : 1.0 - initial release
// ============================================================================
module interrupt_controller #(
    parameter logic [31:0] VECTOR_BASE = 32'd4096
) (
    input  wire logic             clk,
    input  wire logic             rst,
    interrupt_controller_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ALERT   = 2'd1,
        SERVICE = 2'd2
    } state_t;

    state_t     r_state;
    logic [3:0] r_irq_prev;
    logic [3:0] r_pending;
    logic [3:0] r_enable;
    logic [1:0] r_irq_id;
    logic       r_alert;
    logic       r_in_service;

    logic [3:0] w_rise;
    logic [3:0] w_eligible;
    logic [3:0] w_clear;
    logic [1:0] w_grant_id;
    logic       w_take;

    assign w_rise     = bus.irq_in & ~r_irq_prev;
    assign w_eligible = r_pending & r_enable;
    // Acknowledge only counts while an alert is outstanding.
    assign w_take     = (r_state == ALERT) && bus.interrupt;
    // A fresh edge on the serviced source in the same cycle re-sets it.
    assign w_clear    = w_take ? (4'b0001 << r_irq_id) : 4'b0000;

`ifdef INTC_ROUND_ROBIN_EN
    logic [1:0] r_ptr;
    logic [1:0] w_idx;

    // Rotating search: first eligible source after the last granted id.
    always_comb begin
        w_grant_id = 2'd0;
        w_idx      = 2'd0;
        for (int k = 4; k >= 1; k--) begin
            w_idx = r_ptr + 2'(k);
            if (w_eligible[w_idx]) begin
                w_grant_id = w_idx;
            end
        end
    end

    // Pointer follows each accepted grant; reset value makes source 0 first.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= 2'd3;
        end else if (w_take) begin
            r_ptr <= r_irq_id;
        end
    end
`else
    // Fixed priority: lowest eligible index wins.
    always_comb begin
        w_grant_id = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (w_eligible[i]) begin
                w_grant_id = 2'(i);
            end
        end
    end
`endif

    // Edge history, pending and enable registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_irq_prev <= 4'b0000;
            r_pending  <= 4'b0000;
            r_enable   <= 4'b1111;
        end else begin
            r_irq_prev <= bus.irq_in;
            r_pending  <= (r_pending & ~w_clear) | w_rise;
            if (bus.cfg_we) begin
                r_enable <= bus.cfg_wdata;
            end
        end
    end

    // Handshake FSM with registered alert / in_service outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_irq_id     <= 2'd0;
            r_alert      <= 1'b0;
            r_in_service <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if ((w_eligible != 4'b0000) && !bus.interrupt_mask) begin
                        r_state  <= ALERT;
                        r_irq_id <= w_grant_id;
                        r_alert  <= 1'b1;
                    end
                end
                ALERT: begin
                    if (bus.interrupt) begin
                        r_state      <= SERVICE;
                        r_alert      <= 1'b0;
                        r_in_service <= 1'b1;
                    end
                end
                SERVICE: begin
                    if (bus.eoi) begin
                        r_state      <= IDLE;
                        r_in_service <= 1'b0;
                    end
                end
                default: begin
                    r_state      <= IDLE;
                    r_alert      <= 1'b0;
                    r_in_service <= 1'b0;
                end
            endcase
        end
    end

    assign bus.alert      = r_alert;
    assign bus.in_service = r_in_service;
    assign bus.irq_id     = r_irq_id;
    assign bus.vector_pc  = VECTOR_BASE + {26'd0, r_irq_id, 4'b0000};
    assign bus.pending    = r_pending;
    assign bus.enable     = r_enable;

endmodule
`default_nettype wire

// File: tb/tb_interrupt_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_interrupt_controller
// Description : Directed self-checking bench for interrupt_controller.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_interrupt_controller;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    interrupt_controller_if bus ();

    interrupt_controller #(
        .VECTOR_BASE (32'd4096)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_interrupt();
        bus.interrupt = 1'b1;
        tick();
        bus.interrupt = 1'b0;
    endtask

    task automatic pulse_eoi();
        bus.eoi = 1'b1;
        tick();
        bus.eoi = 1'b0;
    endtask

    initial begin
        checks             = 0;
        errors             = 0;
        rst                = 1'b1;
        bus.irq_in         = 4'b0000;
        bus.cfg_we         = 1'b0;
        bus.cfg_wdata      = 4'b0000;
        bus.interrupt_mask = 1'b0;
        bus.interrupt      = 1'b0;
        bus.eoi            = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        check("rst_alert",   32'(bus.alert),      32'd0);
        check("rst_insvc",   32'(bus.in_service), 32'd0);
        check("rst_pending", 32'(bus.pending),    32'd0);
        check("rst_enable",  32'(bus.enable),     32'd15);
        check("rst_irq_id",  32'(bus.irq_id),     32'd0);
        check("rst_vector",  bus.vector_pc,       32'd4096);

        // Single source 2: pending one cycle after edge, alert one later
        bus.irq_in = 4'b0100;
        tick();
        check("s2_pending", 32'(bus.pending), 32'd4);
        check("s2_noalert", 32'(bus.alert),   32'd0);
        tick();
        check("s2_alert",  32'(bus.alert),  32'd1);
        check("s2_id",     32'(bus.irq_id), 32'd2);
        check("s2_vector", bus.vector_pc,   32'd4128);
        tick();
        check("s2_alert_hold", 32'(bus.alert), 32'd1);
        pulse_interrupt();
        check("s2_insvc",   32'(bus.in_service), 32'd1);
        check("s2_alert0",  32'(bus.alert),      32'd0);
        check("s2_pclr",    32'(bus.pending),    32'd0);
        pulse_interrupt();
        check("s2_int_ign", 32'(bus.in_service), 32'd1);
        pulse_eoi();
        check("s2_eoi_insvc", 32'(bus.in_service), 32'd0);
        check("s2_eoi_alert", 32'(bus.alert),      32'd0);
        bus.irq_in = 4'b0000;
        pulse_interrupt();
        check("idle_int_ign", 32'(bus.in_service), 32'd0);

        // Sources 1 and 3 together: 1 first, 3 after eoi
        bus.irq_in = 4'b1010;
        tick();
        tick();
        check("p13_alert", 32'(bus.alert),  32'd1);
        check("p13_id1",   32'(bus.irq_id), 32'd1);
        pulse_eoi();
        check("p13_eoi_ign", 32'(bus.alert), 32'd1);
        pulse_interrupt();
        check("p13_pend3", 32'(bus.pending),    32'd8);
        check("p13_insvc", 32'(bus.in_service), 32'd1);
        pulse_eoi();
        check("p13_idle", 32'(bus.alert), 32'd0);
        tick();
        check("p13_alert3", 32'(bus.alert),  32'd1);
        check("p13_id3",    32'(bus.irq_id), 32'd3);
        check("p13_vec3",   bus.vector_pc,   32'd4144);
        pulse_interrupt();
        pulse_eoi();
        bus.irq_in = 4'b0000;
        tick();

        // Global mask gates IDLE->ALERT only
        bus.interrupt_mask = 1'b1;
        bus.irq_in         = 4'b0001;
        tick();
        tick();
        check("msk_pending", 32'(bus.pending), 32'd1);
        check("msk_noalert", 32'(bus.alert),   32'd0);
        bus.interrupt_mask = 1'b0;
        tick();
        check("msk_alert", 32'(bus.alert),  32'd1);
        check("msk_id0",   32'(bus.irq_id), 32'd0);
        bus.interrupt_mask = 1'b1;
        tick();
        check("msk_hold", 32'(bus.alert), 32'd1);
        pulse_interrupt();
        pulse_eoi();
        bus.interrupt_mask = 1'b0;
        bus.irq_in         = 4'b0000;
        tick();

        // Enable mask: source 0 disabled
        bus.cfg_we    = 1'b1;
        bus.cfg_wdata = 4'b1110;
        tick();
        bus.cfg_we = 1'b0;
        check("en_write", 32'(bus.enable), 32'd14);
        bus.irq_in = 4'b0001;
        tick();
        tick();
        check("en_noalert", 32'(bus.alert),   32'd0);
        check("en_pend0",   32'(bus.pending), 32'd1);
        bus.irq_in = 4'b0011;
        tick();
        tick();
        check("en_alert1", 32'(bus.alert),  32'd1);
        check("en_id1",    32'(bus.irq_id), 32'd1);
        bus.cfg_we    = 1'b1;
        bus.cfg_wdata = 4'b0000;
        tick();
        bus.cfg_we = 1'b0;
        check("en_clr_hold", 32'(bus.alert),  32'd1);
        check("en_clr_val",  32'(bus.enable), 32'd0);
        pulse_interrupt();
        check("en_svc_pend", 32'(bus.pending), 32'd1);

        // Reset during SERVICE
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("rs_insvc",   32'(bus.in_service), 32'd0);
        check("rs_pending", 32'(bus.pending),    32'd0);
        check("rs_enable",  32'(bus.enable),     32'd15);
        check("rs_alert",   32'(bus.alert),      32'd0);
        bus.irq_in = 4'b0000;
        tick();
        tick();

        // New edge on serviced source during acknowledge keeps it pending
        bus.irq_in = 4'b0100;
        tick();
        bus.irq_in = 4'b0000;
        tick();
        check("sw_alert", 32'(bus.alert), 32'd1);
        bus.irq_in = 4'b0100;
        pulse_interrupt();
        check("sw_pending", 32'(bus.pending),    32'd4);
        check("sw_insvc",   32'(bus.in_service), 32'd1);
        pulse_eoi();
        check("sw_idle", 32'(bus.alert), 32'd0);
        tick();
        check("sw_reentry", 32'(bus.alert),  32'd1);
        check("sw_id2",     32'(bus.irq_id), 32'd2);
        pulse_interrupt();
        pulse_eoi();
        bus.irq_in = 4'b0000;
        tick();

`ifdef INTC_ROUND_ROBIN_EN
        // Sources 0 and 1 re-edged each round: grants alternate
        for (int g = 0; g < 4; g++) begin
            int budget;
            bus.irq_in = 4'b0000;
            tick();
            bus.irq_in = 4'b0011;
            tick();
            budget = 0;
            while (!bus.alert && budget < 8) begin
                tick();
                budget++;
            end
            check("rr_alert", 32'(bus.alert),  32'd1);
            check("rr_id",    32'(bus.irq_id), 32'(g % 2));
            pulse_interrupt();
            pulse_eoi();
        end
        bus.irq_in = 4'b0000;
        tick();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
